washer_stop_ctrl: RTL and testbench

- Downstream consumer of the inductive-proximity-sensor stage's washer_found level.
- On each new washer detection: halts the drive motors for a fixed dwell, counts the washer, then re-arms only after the sensor has been clear for a blanking window, so one washer is never counted twice.
- Sits between the navigation logic's motor enable and the motor driver enables.
- Feeds the washer count to the display logic.

---
 rtl/washer_stop_ctrl.sv | 119 +++++++++++
 tb/tb_washer_stop_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/washer_stop_ctrl.sv
// Halts the drive motors for a fixed dwell on each new washer detection and counts it.
// Re-arms only after the sensor has stayed clear for a blanking window.
module washer_stop_ctrl #(
    parameter int STOP_CYCLES  = 100_000_000,
    parameter int BLANK_CYCLES = 10_000_000,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             washer_found,
    input  logic             motor_en_in,
    input  logic             count_clr,
    output logic             motor_en_out,
    output logic             stop_active,
    output logic             stop_pulse,
    output logic [CNT_W-1:0] washer_count,
    output logic             count_sat
);

    localparam int TIMER_W = $clog2(STOP_CYCLES + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        STOP  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [BLANK_W-1:0] blank_cnt;
    logic [BLANK_W-1:0] blank_next;
    logic [CNT_W-1:0]   count_next;
    logic               washer_prev;
    logic               rise;
    logic               count_inc;

    assign rise = washer_found & ~washer_prev;

    always_comb begin
        state_next = state;
        timer_next = timer;
        blank_next = blank_cnt;
        count_inc  = 1'b0;
        case (state)
            DRIVE: begin
                if (rise) begin
                    state_next = STOP;
                    timer_next = TIMER_W'(STOP_CYCLES - 1);
                    count_inc  = 1'b1;
                end
            end
            STOP: begin
                if (timer == '0) begin
                    state_next = CLEAR;
                    blank_next = '0;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
            CLEAR: begin
                // Any high sample restarts the blanking window from scratch.
                if (washer_found) begin
                    blank_next = '0;
                end else if (blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) begin
                    state_next = DRIVE;
                    blank_next = '0;
                end else begin
                    blank_next = blank_cnt + BLANK_W'(1);
                end
            end
            default: begin
                state_next = DRIVE;
                timer_next = '0;
                blank_next = '0;
            end
        endcase
    end

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    always_comb begin
        count_next = washer_count;
        if (count_clr) begin
            count_next = '0;
        end else if (count_inc && !(&washer_count)) begin
            count_next = washer_count + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= DRIVE;
            timer        <= '0;
            blank_cnt    <= '0;
            washer_prev  <= 1'b1;
            washer_count <= '0;
            count_sat    <= 1'b0;
            motor_en_out <= 1'b0;
            stop_active  <= 1'b0;
            stop_pulse   <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            blank_cnt    <= blank_next;
            washer_prev  <= washer_found;
            washer_count <= count_next;
            count_sat    <= &count_next;
            motor_en_out <= motor_en_in && (state_next != STOP);
            stop_active  <= (state_next == STOP);
            stop_pulse   <= count_inc;
        end
    end

    a_pulse_single: assert property (@(posedge CLK) disable iff (RST) stop_pulse |=> !stop_pulse);
    a_motor_off_in_stop: assert property (@(posedge CLK) stop_active |-> !motor_en_out);

endmodule

// File: tb/tb_washer_stop_ctrl.sv
// Directed bench for washer_stop_ctrl with short dwell/blank windows.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_washer_stop_ctrl;

    localparam int STOP  = 8;
    localparam int BLANK = 4;
    localparam int CW    = 4;

    logic          CLK;
    logic          RST;
    logic          washer_found;
    logic          motor_en_in;
    logic          count_clr;
    logic          motor_en_out;
    logic          stop_active;
    logic          stop_pulse;
    logic [CW-1:0] washer_count;
    logic          count_sat;

    int checks;
    int errors;

    washer_stop_ctrl #(
        .STOP_CYCLES (STOP),
        .BLANK_CYCLES(BLANK),
        .CNT_W       (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .washer_found(washer_found),
        .motor_en_in (motor_en_in),
        .count_clr   (count_clr),
        .motor_en_out(motor_en_out),
        .stop_active (stop_active),
        .stop_pulse  (stop_pulse),
        .washer_count(washer_count),
        .count_sat   (count_sat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Holds the given inputs across the requested number of rising edges.
    task automatic applyStimulus(input logic found, input logic en, input logic clr, input int cycles);
        washer_found = found;
        motor_en_in  = en;
        count_clr    = clr;
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    task automatic washerEvent();
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
    endtask

    task automatic settle();
        applyStimulus(1'b0, 1'b1, 1'b0, STOP + BLANK + 2);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("rst_motor", motor_en_out, 0);
        checkOutput("rst_stop_active", stop_active, 0);
        checkOutput("rst_pulse", stop_pulse, 0);
        checkOutput("rst_count", washer_count, 0);
        checkOutput("rst_sat", count_sat, 0);

        RST = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        checkOutput("drive_motor", motor_en_out, 1);

        washerEvent();
        checkOutput("s1_motor_off", motor_en_out, 0);
        checkOutput("s1_pulse", stop_pulse, 1);
        checkOutput("s1_stop_active", stop_active, 1);
        checkOutput("s1_count", washer_count, 1);
        for (int i = 1; i < STOP; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1);
            checkOutput("s1_dwell_active", stop_active, 1);
            checkOutput("s1_dwell_pulse", stop_pulse, 0);
            checkOutput("s1_dwell_motor", motor_en_out, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("s1_clear_active", stop_active, 0);
        checkOutput("s1_clear_motor", motor_en_out, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 21);
        checkOutput("s1_held_count", washer_count, 1);
        // Three clear cycles are one short of re-arming, so this rise is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("s1_early_rise_count", washer_count, 1);
        checkOutput("s1_early_rise_pulse", stop_pulse, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, BLANK);

        washerEvent();
        checkOutput("s2_rearm_count", washer_count, 2);
        checkOutput("s2_rearm_pulse", stop_pulse, 1);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(((i >> 1) & 1) == 0, 1'b1, 1'b0, 1);
            checkOutput("s2_toggle_count", washer_count, 2);
            checkOutput("s2_toggle_pulse", stop_pulse, 0);
            checkOutput("s2_toggle_active", stop_active, (i < STOP) ? 1 : 0);
            checkOutput("s2_toggle_motor", motor_en_out, (i < STOP) ? 0 : 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        washerEvent();
        checkOutput("s2_next_count", washer_count, 3);
        checkOutput("s2_next_pulse", stop_pulse, 1);
        settle();

        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("s3_clr_count", washer_count, 0);
        checkOutput("s3_clr_sat", count_sat, 0);
        for (int k = 1; k <= 16; k++) begin
            washerEvent();
            checkOutput("s3_count", washer_count, (k > 15) ? 15 : k);
            checkOutput("s3_sat", count_sat, (k >= 15) ? 1 : 0);
            settle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("s3_clr2_count", washer_count, 0);
        checkOutput("s3_clr2_sat", count_sat, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("s4_clr_wins_count", washer_count, 0);
        checkOutput("s4_pulse", stop_pulse, 1);
        checkOutput("s4_active", stop_active, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, STOP - 1);
        checkOutput("s4_dwell_end_active", stop_active, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("s4_after_dwell_active", stop_active, 0);
        checkOutput("s4_after_dwell_count", washer_count, 0);
        settle();

        RST = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2);
        RST = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        checkOutput("s5_held_count", washer_count, 0);
        checkOutput("s5_held_active", stop_active, 0);
        checkOutput("s5_held_motor", motor_en_out, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        washerEvent();
        checkOutput("s5_rise_count", washer_count, 1);
        checkOutput("s5_rise_pulse", stop_pulse, 1);
        settle();

        washerEvent();
        checkOutput("s6_count", washer_count, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        checkOutput("s6_mid_active", stop_active, 1);
        RST = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("s6_rst_motor", motor_en_out, 0);
        checkOutput("s6_rst_active", stop_active, 0);
        checkOutput("s6_rst_count", washer_count, 0);
        checkOutput("s6_rst_pulse", stop_pulse, 0);
        RST = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        checkOutput("s6_drive_motor", motor_en_out, 1);
        checkOutput("s6_drive_active", stop_active, 0);
        washerEvent();
        checkOutput("s6_after_count", washer_count, 1);
        checkOutput("s6_after_pulse", stop_pulse, 1);
        checkOutput("s6_after_motor", motor_en_out, 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
